// File: rtl/hwpe_stream_tcdm_fifo_store_param.sv
// TCDM store buffer: queues write transactions from a streamer and replays them in order on a
// TCDM master port, with occupancy status, sticky read-request error and a flush/drain handshake.
module hwpe_stream_tcdm_fifo_store_param #(
    parameter int unsigned DATA_WIDTH         = 32,
    parameter int unsigned ADDR_WIDTH         = 32,
    parameter int unsigned FIFO_DEPTH         = 8,
    parameter int unsigned ALMOST_FULL_THRESH = FIFO_DEPTH - 2
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             flush_i,
    output logic                             flush_done_o,
    input  logic                             tcdm_slave_req_i,
    output logic                             tcdm_slave_gnt_o,
    input  logic [ADDR_WIDTH-1:0]            tcdm_slave_add_i,
    input  logic                             tcdm_slave_wen_i,
    input  logic [DATA_WIDTH/8-1:0]          tcdm_slave_be_i,
    input  logic [DATA_WIDTH-1:0]            tcdm_slave_data_i,
    output logic                             tcdm_master_req_o,
    input  logic                             tcdm_master_gnt_i,
    output logic [ADDR_WIDTH-1:0]            tcdm_master_add_o,
    output logic                             tcdm_master_wen_o,
    output logic [DATA_WIDTH/8-1:0]          tcdm_master_be_o,
    output logic [DATA_WIDTH-1:0]            tcdm_master_data_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  count_o,
    output logic                             almost_full_o,
    output logic                             err_o
);

    localparam int unsigned BE_WIDTH  = DATA_WIDTH / 8;
    localparam int unsigned PTR_WIDTH = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_WIDTH = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned ENTRY_W   = ADDR_WIDTH + BE_WIDTH + DATA_WIDTH;

    localparam logic [CNT_WIDTH-1:0] FULL_CNT  = CNT_WIDTH'(FIFO_DEPTH);
    localparam logic [CNT_WIDTH-1:0] AF_THRESH = CNT_WIDTH'(ALMOST_FULL_THRESH);

    typedef enum logic [1:0] {StIdle, StDrain, StDone} state_e;

    state_e                 state_q, state_d;
    logic [PTR_WIDTH-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_WIDTH-1:0]   count_q, count_d;
    logic                   almost_full_q;
    logic                   err_q;
    logic [ENTRY_W-1:0]     mem_q [FIFO_DEPTH];
    logic [ENTRY_W-1:0]     head;

    logic full, empty, push, pop, rd_req;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);

    assign tcdm_slave_gnt_o = !full && (state_q == StIdle) && !rst_i;
    assign push   = tcdm_slave_req_i && tcdm_slave_gnt_o && !tcdm_slave_wen_i;
    // Read requests are granted so the requester never stalls, but are dropped.
    assign rd_req = tcdm_slave_req_i && tcdm_slave_gnt_o && tcdm_slave_wen_i;
    assign pop    = !empty && tcdm_master_gnt_i;

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_WIDTH'(1);
            2'b01:   count_d = count_q - CNT_WIDTH'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (flush_i) state_d = StDrain;
            StDrain: if (count_q == '0) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= StIdle;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            almost_full_q <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            almost_full_q <= (count_d >= AF_THRESH);
            if (push) wr_ptr_q <= wr_ptr_q + PTR_WIDTH'(1);
            if (pop) rd_ptr_q <= rd_ptr_q + PTR_WIDTH'(1);
            if (rd_req) err_q <= 1'b1;
        end
    end

    // Storage is deliberately not reset; invalid entries are hidden by req_o = 0.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= {tcdm_slave_add_i, tcdm_slave_be_i, tcdm_slave_data_i};
    end

    assign head = mem_q[rd_ptr_q];

    assign tcdm_master_req_o  = !empty;
    assign tcdm_master_wen_o  = 1'b0;
    assign tcdm_master_add_o  = head[ENTRY_W-1 -: ADDR_WIDTH];
    assign tcdm_master_be_o   = head[DATA_WIDTH +: BE_WIDTH];
    assign tcdm_master_data_o = head[DATA_WIDTH-1:0];

    assign count_o       = count_q;
    assign almost_full_o = almost_full_q;
    assign err_o         = err_q;
    assign flush_done_o  = (state_q == StDone);

endmodule

// File: tb/tb_hwpe_stream_tcdm_fifo_store_param.sv
// Directed self-checking bench for the TCDM store FIFO (default parameters, depth 8).
module tb_hwpe_stream_tcdm_fifo_store_param;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        flush_done;
    logic        s_req, s_gnt, s_wen;
    logic [31:0] s_add, s_data;
    logic [3:0]  s_be;
    logic        m_req, m_gnt, m_wen;
    logic [31:0] m_add, m_data;
    logic [3:0]  m_be;
    logic [3:0]  count;
    logic        almost_full, err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    hwpe_stream_tcdm_fifo_store_param dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .flush_i            (flush),
        .flush_done_o       (flush_done),
        .tcdm_slave_req_i   (s_req),
        .tcdm_slave_gnt_o   (s_gnt),
        .tcdm_slave_add_i   (s_add),
        .tcdm_slave_wen_i   (s_wen),
        .tcdm_slave_be_i    (s_be),
        .tcdm_slave_data_i  (s_data),
        .tcdm_master_req_o  (m_req),
        .tcdm_master_gnt_i  (m_gnt),
        .tcdm_master_add_o  (m_add),
        .tcdm_master_wen_o  (m_wen),
        .tcdm_master_be_o   (m_be),
        .tcdm_master_data_o (m_data),
        .count_o            (count),
        .almost_full_o      (almost_full),
        .err_o              (err)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        s_req  = 1'b1;
        s_wen  = 1'b0;
        s_add  = a;
        s_data = d;
        s_be   = be;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; s_req = 1'b0; s_wen = 1'b0;
        s_add = '0; s_data = '0; s_be = '0; m_gnt = 1'b0;

        // Reset state
        tick();
        #1 check_eq("gnt_in_reset", s_gnt, 0);
        tick();
        rst = 1'b0;
        #1;
        check_eq("rst_count", count, 0);
        check_eq("rst_mreq", m_req, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_done", flush_done, 0);
        check_eq("rst_af", almost_full, 0);
        check_eq("rst_gnt", s_gnt, 1);

        // Three writes with the master always granting
        m_gnt = 1'b1;
        drive_wr(32'h100, 32'hA, 4'hF);
        #1 check_eq("t1_mreq_empty", m_req, 0);
        tick();
        drive_wr(32'h104, 32'hB, 4'h3);
        #1;
        check_eq("t1_mreq0", m_req, 1);
        check_eq("t1_add0", m_add, 32'h100);
        check_eq("t1_data0", m_data, 32'hA);
        check_eq("t1_be0", m_be, 4'hF);
        check_eq("t1_wen0", m_wen, 0);
        tick();
        drive_wr(32'h108, 32'hC, 4'h8);
        #1;
        check_eq("t1_add1", m_add, 32'h104);
        check_eq("t1_be1", m_be, 4'h3);
        check_eq("t1_data1", m_data, 32'hB);
        tick();
        s_req = 1'b0;
        #1;
        check_eq("t1_add2", m_add, 32'h108);
        check_eq("t1_be2", m_be, 4'h8);
        check_eq("t1_data2", m_data, 32'hC);
        check_eq("t1_count_mid", count, 1);
        tick();
        check_eq("t1_count_end", count, 0);
        check_eq("t1_mreq_end", m_req, 0);

        // Fill to full with the master stalled
        m_gnt = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive_wr(32'h300 + 4 * i, i, 4'hF);
            #1 check_eq("t2_gnt_fill", s_gnt, 1);
            tick();
            check_eq("t2_count_fill", count, i + 1);
            check_eq("t2_af_fill", almost_full, (i + 1 >= 6) ? 1 : 0);
        end
        drive_wr(32'h400, 32'h99, 4'h5);
        #1 check_eq("t2_gnt_full", s_gnt, 0);
        tick();
        check_eq("t2_count_full", count, 8);
        m_gnt = 1'b1;
        #1;
        check_eq("t2_gnt_full_mgnt", s_gnt, 0);
        check_eq("t2_head0", m_add, 32'h300);
        tick();
        check_eq("t2_gnt_after_pop", s_gnt, 1);
        check_eq("t2_head1", m_add, 32'h304);
        check_eq("t2_count_7", count, 7);
        tick();
        s_req = 1'b0;
        check_eq("t2_count_pushpop", count, 7);
        for (int j = 2; j < 8; j++) begin
            #1;
            check_eq("t2_pop_add", m_add, 32'h300 + 4 * j);
            check_eq("t2_pop_data", m_data, j);
            tick();
        end
        check_eq("t2_ninth_add", m_add, 32'h400);
        check_eq("t2_ninth_data", m_data, 32'h99);
        check_eq("t2_ninth_be", m_be, 4'h5);
        tick();
        check_eq("t2_count_end", count, 0);
        check_eq("t2_af_end", almost_full, 0);

        // Steady push/pop at occupancy 4
        m_gnt = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive_wr(32'h500 + 4 * k, 32'h10 + k, 4'hF);
            tick();
        end
        m_gnt = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive_wr(32'h510 + 4 * i, 32'h14 + i, 4'hF);
            #1;
            check_eq("t3_data", m_data, 32'h10 + i);
            check_eq("t3_count", count, 4);
            tick();
        end
        s_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check_eq("t3_tail", m_data, 32'h24 + k);
            tick();
        end
        check_eq("t3_empty", m_req, 0);

        // Illegal read request
        s_req = 1'b1; s_wen = 1'b1; s_add = 32'h200;
        #1 check_eq("t4_rd_gnt", s_gnt, 1);
        tick();
        s_req = 1'b0; s_wen = 1'b0;
        check_eq("t4_err", err, 1);
        check_eq("t4_no_issue", m_req, 0);
        check_eq("t4_count", count, 0);
        drive_wr(32'h204, 32'h1, 4'hF);
        tick();
        s_req = 1'b0;
        tick();
        check_eq("t4_err_sticky", err, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("t4_err_clr", err, 0);

        // Flush with 5 queued entries
        m_gnt = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drive_wr(32'h600 + 4 * k, 32'h50 + k, 4'hF);
            tick();
        end
        s_req = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        m_gnt = 1'b1;
        drive_wr(32'h700, 32'h77, 4'hF);
        for (int k = 0; k < 5; k++) begin
            #1;
            check_eq("t5_gnt_drain", s_gnt, 0);
            check_eq("t5_done_early", flush_done, 0);
            check_eq("t5_pop_data", m_data, 32'h50 + k);
            tick();
        end
        check_eq("t5_count0", count, 0);
        check_eq("t5_done_not_yet", flush_done, 0);
        check_eq("t5_gnt_still0", s_gnt, 0);
        tick();
        s_req = 1'b0;
        check_eq("t5_done", flush_done, 1);
        check_eq("t5_gnt_done", s_gnt, 0);
        tick();
        check_eq("t5_done_pulse", flush_done, 0);
        check_eq("t5_gnt_idle", s_gnt, 1);
        check_eq("t5_no_push", count, 0);

        // Flush on an empty FIFO
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_eq("t5e_drain_done", flush_done, 0);
        check_eq("t5e_drain_gnt", s_gnt, 0);
        tick();
        check_eq("t5e_done", flush_done, 1);
        tick();
        check_eq("t5e_done_off", flush_done, 0);
        check_eq("t5e_gnt", s_gnt, 1);

        // Reset during drain
        m_gnt = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive_wr(32'h800 + 4 * k, 32'h80 + k, 4'hF);
            tick();
        end
        s_req = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_eq("t6_gnt_drain", s_gnt, 0);
        check_eq("t6_count3", count, 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check_eq("t6_mreq", m_req, 0);
        check_eq("t6_count", count, 0);
        check_eq("t6_done", flush_done, 0);
        check_eq("t6_gnt", s_gnt, 1);
        tick();
        check_eq("t6_no_done", flush_done, 0);
        check_eq("t6_mreq_after", m_req, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
